// File: rtl/dda_step_pkg.sv
// rtl/dda_step_pkg.sv - shared defaults, widths and magnitude clamp for the DDA step generator
package dda_step_pkg;

  localparam int NCH_DEF     = 2;
  localparam int MAG_W_DEF   = 7;
  localparam int NMAX_DEF    = 50;
  localparam int CLK_DIV_DEF = 200;

  localparam int ACC_W  = $clog2(2 * NMAX_DEF);
  localparam int SLOT_W = $clog2(NMAX_DEF);
  localparam int DIV_W  = $clog2(CLK_DIV_DEF);
  localparam int CH_W   = (NCH_DEF > 1) ? $clog2(NCH_DEF) : 1;

  // Command word layout: {dir, mag}, with dir at bit MAG_W.
  function automatic int cmd_dir_bit(input int mag_w);
    return mag_w;
  endfunction

  function automatic int clamp_mag(input int mag, input int nmax);
    return (mag > nmax) ? nmax : mag;
  endfunction

endpackage

// File: rtl/dda_step_chan.sv
// rtl/dda_step_chan.sv - one step/dir channel: prescaler, slot/phase, DDA accumulator, one-deep buffer
module dda_step_chan
  import dda_step_pkg::*;
#(
  parameter int NMAX    = NMAX_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF,
  localparam int AW     = $clog2(2 * NMAX),
  localparam int SW     = $clog2(NMAX),
  localparam int DW     = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_dir,
  input  logic [AW-1:0] wr_mag,
  input  logic          ovr_clr,
  output logic          pulse,
  output logic          dir,
  output logic          busy,
  output logic          full,
  output logic          ovr
);

  logic [DW-1:0] presc;
  logic [SW-1:0] slot;
  logic          phase;
  logic [AW-1:0] acc;
  logic [AW-1:0] mag;
  logic [AW-1:0] buf_mag;
  logic          buf_dir;

  logic          tick;
  logic          pend;
  logic          from_buf;
  logic          start;
  logic          store;
  logic          drop;
  logic [AW-1:0] sum;

  assign tick     = busy && (presc == DW'(CLK_DIV - 1));
  assign pend     = tick && phase && (slot == SW'(NMAX - 1));
  assign from_buf = pend && full;
  assign start    = from_buf || (wr_en && (!busy || pend));
  // At period end a full buffer is promoted, so the incoming write refills it.
  assign store    = wr_en && busy && (pend ? full : !full);
  assign drop     = wr_en && busy && !pend && full;
  assign sum      = acc + mag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc   <= '0;
      slot    <= '0;
      phase   <= 1'b0;
      acc     <= '0;
      mag     <= '0;
      buf_mag <= '0;
      buf_dir <= 1'b0;
      pulse   <= 1'b0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      full    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (store) begin
        buf_dir <= wr_dir;
        buf_mag <= wr_mag;
        full    <= 1'b1;
      end else if (from_buf) begin
        full <= 1'b0;
      end

      if (drop) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end

      if (start) begin
        busy  <= 1'b1;
        dir   <= from_buf ? buf_dir : wr_dir;
        mag   <= from_buf ? buf_mag : wr_mag;
        acc   <= AW'(NMAX - 1);
        presc <= '0;
        slot  <= '0;
        phase <= 1'b0;
        pulse <= 1'b0;
      end else if (pend) begin
        busy  <= 1'b0;
        pulse <= 1'b0;
        phase <= 1'b0;
        presc <= '0;
        slot  <= '0;
      end else if (busy) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (!phase) begin
            if (sum >= AW'(NMAX)) begin
              acc   <= sum - AW'(NMAX);
              pulse <= 1'b1;
            end else begin
              acc   <= sum;
              pulse <= 1'b0;
            end
            phase <= 1'b1;
          end else begin
            pulse <= 1'b0;
            phase <= 1'b0;
            slot  <= slot + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dda_step_gen.sv
// rtl/dda_step_gen.sv - multi-channel step/dir pulse generator: write edge detect, decode, channel array
module dda_step_gen
  import dda_step_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int MAG_W   = MAG_W_DEF,
  parameter int NMAX    = NMAX_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW     = $clog2(2 * NMAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CW-1:0]    wr_ch,
  input  logic [MAG_W:0]   wr_data,
  input  logic             ovr_clr,
  output logic [NCH-1:0]   pulse,
  output logic [NCH-1:0]   dir,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   full,
  output logic [NCH-1:0]   ovr
);

  logic          pre_wr;
  logic          wr_rise;
  logic [AW-1:0] mag_c;
  logic          cmd_dir;

  // The detector keeps following wr during reset so a level held across reset is not a new write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_wr <= wr;
    end else begin
      pre_wr <= wr;
    end
  end

  assign wr_rise = wr && !pre_wr && (int'(wr_ch) < NCH);
  assign mag_c   = AW'(clamp_mag(int'(wr_data[MAG_W-1:0]), NMAX));
  assign cmd_dir = wr_data[cmd_dir_bit(MAG_W)];

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    dda_step_chan #(
      .NMAX    (NMAX),
      .CLK_DIV (CLK_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_rise && (wr_ch == CW'(g))),
      .wr_dir  (cmd_dir),
      .wr_mag  (mag_c),
      .ovr_clr (ovr_clr),
      .pulse   (pulse[g]),
      .dir     (dir[g]),
      .busy    (busy[g]),
      .full    (full[g]),
      .ovr     (ovr[g])
    );
  end

endmodule
